// File: rtl/memory_pkg.sv
// Shared data-memory definitions: widths, access sizes, and load/store unit types.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned MEM_WORD_WIDTH = 32;
  localparam int unsigned REG_IDX_W      = 5;

  localparam logic [1:0] LS_SINGLE   = 2'd0;
  localparam logic [1:0] LS_HALFWORD = 2'd1;
  localparam logic [1:0] LS_WORD     = 2'd2;

  typedef enum logic [1:0] {
    ERR_MISALIGN = 2'd0,
    ERR_ACCESS   = 2'd1,
    ERR_ILLEGAL  = 2'd2
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } lsu_state_e;

  // Operation context carried from accept to result.
  typedef struct packed {
    logic                 store;
    logic [REG_IDX_W-1:0] rd;
  } lsu_op_t;

endpackage

// File: rtl/lsu_addr_check.sv
// Effective-address adder and prioritized pre-check (illegal > range > misalign).
// Misalignment check only when LSU_ALIGN_CHECK_EN is defined.
module lsu_addr_check
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH
) (
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_base,
  input  logic [31:0] ex_offset,
  output logic [31:0] eaddr_c,
  output logic        fault_c,
  output lsu_err_e    cause_c
);

  logic illegal_c;
  logic range_err_c;
  logic misalign_c;

  assign eaddr_c     = ex_base + ex_offset;
  assign illegal_c   = (ex_load == ex_store) || (ex_size == 2'b11);
  // Shift is zero when ADDR_W covers the full 32-bit space.
  assign range_err_c = (eaddr_c >> ADDR_W) != 32'd0;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_c = ((ex_size == LS_HALFWORD) && eaddr_c[0]) ||
                      ((ex_size == LS_WORD) && (eaddr_c[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  always_comb begin
    fault_c = 1'b1;
    cause_c = ERR_ILLEGAL;
    if (illegal_c) begin
      cause_c = ERR_ILLEGAL;
    end else if (range_err_c) begin
      cause_c = ERR_ACCESS;
    end else if (misalign_c) begin
      cause_c = ERR_MISALIGN;
    end else begin
      fault_c = 1'b0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one execute-stage op, issues it on dmem_*, returns registered result.
// Optional misalignment faults when LSU_ALIGN_CHECK_EN is defined.
module load_store_unit
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH,
  parameter int unsigned WORD_W = MEM_WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic              ex_unsigned,
  input  logic [1:0]        ex_size,
  input  logic [31:0]       ex_base,
  input  logic [31:0]       ex_offset,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req,
  output logic              dmem_write_en,
  output logic              dmem_l_unsigned,
  output logic [1:0]        dmem_n_bytes,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_store_data,
  input  logic              dmem_addr_err,
  input  logic [WORD_W-1:0] dmem_load_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [WORD_W-1:0] wb_data,
  output logic              st_done,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [31:0]       err_addr
);

  lsu_state_e        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [31:0]       eaddr_q, eaddr_d;

  logic              ex_ready_d;
  logic              dmem_req_d;
  logic              dmem_write_en_d;
  logic              dmem_l_unsigned_d;
  logic [1:0]        dmem_n_bytes_d;
  logic [ADDR_W-1:0] dmem_addr_d;
  logic [WORD_W-1:0] dmem_store_data_d;
  logic              wb_valid_d;
  logic [4:0]        wb_rd_d;
  logic [WORD_W-1:0] wb_data_d;
  logic              st_done_d;
  logic              err_valid_d;
  logic [1:0]        err_cause_d;
  logic [31:0]       err_addr_d;

  logic [31:0]       eaddr_c;
  logic              fault_c;
  lsu_err_e          cause_c;

  lsu_addr_check #(
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .ex_load   (ex_load),
    .ex_store  (ex_store),
    .ex_size   (ex_size),
    .ex_base   (ex_base),
    .ex_offset (ex_offset),
    .eaddr_c   (eaddr_c),
    .fault_c   (fault_c),
    .cause_c   (cause_c)
  );

  // Next-state and registered-output values; dmem_* payload holds outside accept.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    eaddr_d           = eaddr_q;
    dmem_req_d        = 1'b0;
    dmem_write_en_d   = dmem_write_en;
    dmem_l_unsigned_d = dmem_l_unsigned;
    dmem_n_bytes_d    = dmem_n_bytes;
    dmem_addr_d       = dmem_addr;
    dmem_store_data_d = dmem_store_data;
    wb_valid_d        = 1'b0;
    wb_rd_d           = wb_rd;
    wb_data_d         = wb_data;
    st_done_d         = 1'b0;
    err_valid_d       = 1'b0;
    err_cause_d       = err_cause;
    err_addr_d        = err_addr;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (fault_c) begin
            err_valid_d = 1'b1;
            err_cause_d = cause_c;
            err_addr_d  = eaddr_c;
          end else begin
            state_d           = ISSUE;
            dmem_req_d        = 1'b1;
            dmem_write_en_d   = ex_store;
            dmem_l_unsigned_d = ex_load & ex_unsigned;
            dmem_n_bytes_d    = ex_size;
            dmem_addr_d       = eaddr_c[ADDR_W-1:0];
            dmem_store_data_d = ex_store_data;
            op_d.store        = ex_store;
            op_d.rd           = ex_rd;
            eaddr_d           = eaddr_c;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
        if (dmem_addr_err) begin
          err_valid_d = 1'b1;
          err_cause_d = ERR_ACCESS;
          err_addr_d  = eaddr_q;
        end else if (!op_q.store) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = op_q.rd;
          wb_data_d  = dmem_load_data;
        end else begin
          st_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ex_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      eaddr_q         <= '0;
      ex_ready        <= 1'b1;
      dmem_req        <= 1'b0;
      dmem_write_en   <= 1'b0;
      dmem_l_unsigned <= 1'b0;
      dmem_n_bytes    <= '0;
      dmem_addr       <= '0;
      dmem_store_data <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      st_done         <= 1'b0;
      err_valid       <= 1'b0;
      err_cause       <= '0;
      err_addr        <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      eaddr_q         <= eaddr_d;
      ex_ready        <= ex_ready_d;
      dmem_req        <= dmem_req_d;
      dmem_write_en   <= dmem_write_en_d;
      dmem_l_unsigned <= dmem_l_unsigned_d;
      dmem_n_bytes    <= dmem_n_bytes_d;
      dmem_addr       <= dmem_addr_d;
      dmem_store_data <= dmem_store_data_d;
      wb_valid        <= wb_valid_d;
      wb_rd           <= wb_rd_d;
      wb_data         <= wb_data_d;
      st_done         <= st_done_d;
      err_valid       <= err_valid_d;
      err_cause       <= err_cause_d;
      err_addr        <= err_addr_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data memory port. Accepts one load or store per transaction from the execute stage, computes the effective address and checks it. It drives the data memory request interface, captures the registered response, and returns write-back data or a fault to the pipeline. It sits between execute and write-back and owns the `dmem_*` signals.

## Interface

**Parameters**
- `ADDR_W`, default `memory_pkg::MEM_ADDR_WIDTH`: data memory address width.
- `WORD_W`, default `memory_pkg::MEM_WORD_WIDTH`: data word width (32).

**Ports**
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `ex_valid`, input, 1: execute stage presents an operation.
- `ex_ready`, output, 1: LSU can accept; transfer occurs when `ex_valid & ex_ready`.
- `ex_load`, input, 1: operation is a load.
- `ex_store`, input, 1: operation is a store.
- `ex_unsigned`, input, 1: LBU/LHU.
- `ex_size`, input, 2: `LS_SINGLE`, `LS_HALFWORD` or `LS_WORD`.
- `ex_base`, input, 32: rs1 value.
- `ex_offset`, input, 32: sign-extended immediate.
- `ex_store_data`, input, `WORD_W`: rs2 value.
- `ex_rd`, input, 5: load destination register.
- `dmem_req`, output, 1: memory request.
- `dmem_write_en`, output, 1: store request.
- `dmem_l_unsigned`, output, 1: unsigned load.
- `dmem_n_bytes`, output, 2: access size.
- `dmem_addr`, output, `ADDR_W`: byte address.
- `dmem_store_data`, output, `WORD_W`: store data.
- `dmem_addr_err`, input, 1: memory range error, valid one cycle after `dmem_req`.
- `dmem_load_data`, input, `WORD_W`: load data, valid one cycle after `dmem_req`.
- `wb_valid`, output, 1: single-cycle pulse; load data is ready.
- `wb_rd`, output, 5: destination register.
- `wb_data`, output, `WORD_W`: extended load data.
- `st_done`, output, 1: single-cycle pulse; store committed.
- `err_valid`, output, 1: single-cycle fault pulse.
- `err_cause`, output, 2: `lsu_err_e` value.
- `err_addr`, output, 32: faulting effective address.

## Operation

- **FSM states:** `IDLE`, `ISSUE`, `WAIT`. `ex_ready` = (state == `IDLE`).
- **On accept:**
  - Latch the operation.
  - `eaddr = ex_base + ex_offset`, mod 2^32.
  - `dmem_addr = eaddr[ADDR_W-1:0]`.
- **Pre-checks at accept.** Priority order: illegal, then out-of-range, then misaligned.
  - Illegal: `ex_load` == `ex_store` (both set or both clear), or `ex_size` == 2'b11. Cause `ERR_ILLEGAL`.
  - Out of range: `ADDR_W` < 32 and `eaddr[31:ADDR_W]` != 0. Cause `ERR_ACCESS`.
  - Misaligned: halfword with `eaddr[0]`, or word with `eaddr[1:0]` != 0. Cause `ERR_MISALIGN`.
  - A failed pre-check stays in `IDLE` and never raises `dmem_req`. It asserts `err_valid` the next cycle.
- **`ISSUE`:** `dmem_req` = 1. All `dmem_*` outputs are driven from latched registers. Next state is `WAIT`.
- **`WAIT`:** sample `dmem_addr_err` and `dmem_load_data`, then return to `IDLE`.
  - If `dmem_addr_err`: `err_valid`, cause `ERR_ACCESS`.
  - Else if load: `wb_valid`, with `wb_data` = `dmem_load_data`. The memory performs the extension; the LSU passes data through.
  - Else: `st_done`.
- **Result exclusivity:** exactly one of `wb_valid`, `st_done` or `err_valid` pulses per accepted operation.
- **Idle outputs:** `dmem_req` = 0 outside `ISSUE`. Other `dmem_*` outputs hold their last values.
- **Reset mid-operation:** FSM returns to `IDLE`, and `dmem_req` drops the same cycle the reset is sampled. The pending operation is discarded with no result pulse. A store already issued may have written memory.

## Timing

- **Reset values:** state `IDLE`; `ex_ready`=1. `dmem_req`, `dmem_write_en`, `dmem_l_unsigned`, `wb_valid`, `st_done`, `err_valid` = 0. `dmem_n_bytes`, `dmem_addr`, `dmem_store_data`, `wb_rd`, `wb_data`, `err_cause`, `err_addr` = 0.
- **Normal path:** accept in cycle 0, `dmem_req` in cycle 1, capture in cycle 2. `wb_valid`/`st_done`/`err_valid` is high in cycle 3 and `ex_ready` is 1 again in cycle 3.
  - Result latency: 3 cycles.
  - Throughput: one operation per 3 cycles.
  - A new accept in cycle 3 overlaps the previous result pulse legally.
- **Pre-check fault:** `err_valid` in cycle 1, `ex_ready` stays 1. Back-to-back faulting operations give one pulse each.
- **Result outputs:** all registered; no combinational path from `dmem_load_data` to `wb_data`.

## Configuration

- **`LSU_ALIGN_CHECK_EN` defined:** misaligned pre-check active, as above.
- **`LSU_ALIGN_CHECK_EN` undefined:** no misalignment check. Unaligned halfword/word accesses go to memory unchanged (the memory is byte-addressed), and `ERR_MISALIGN` is never produced.

## Structure

- **Add to `memory_pkg`:**
  - `lsu_err_e`: `ERR_MISALIGN`=0, `ERR_ACCESS`=1, `ERR_ILLEGAL`=2.
  - `lsu_state_e`: `IDLE`, `ISSUE`, `WAIT`.
  - Reuse `LS_SINGLE`, `LS_HALFWORD`, `LS_WORD`.
- **Sub-module:** `lsu_addr_check`, combinational, computing `eaddr` and the prioritized fault/cause.

## Test plan

- **Word load:** memory preloaded 0x4000 = 0xDEADBEEF; load word from base 0x3FF0 + offset 0x10, rd=5 → `dmem_req` in cycle 1 with addr 0x4000; `wb_valid` in cycle 3 with `wb_rd`=5, `wb_data`=0xDEADBEEF.
- **Byte loads:** signed LB at 0x4003 → 0xFFFFFFDE; LBU at the same address → 0x000000DE.
- **Store round trip:** SH 0x1234ABCD at 0x4006 → `st_done` in cycle 3; then LW 0x4004 → upper half 0xABCD.
- **Misaligned:** LW at 0x4002 → `err_valid` in cycle 1, `ERR_MISALIGN`, `err_addr`=0x4002, no `dmem_req`. With the macro undefined → request issued with addr 0x4002.
- **Access fault:** load at 0x0010 → `ERR_ACCESS` in cycle 3. Base 0xFFFFFFFC + offset 8 wraps to 0x4 → request issued, `ERR_ACCESS`. Both `ex_load` and `ex_store` set → `ERR_ILLEGAL` in cycle 1.
- **Reset mid-operation:** `rst` asserted in `WAIT` → no result pulse; `ex_ready`=1 and all outputs at their reset values the next cycle.
